// File: rtl/wb_pkg.sv
// Shared widths and the queued writeback entry type.
// Imported by every file of the writeback queue.
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_bypass_match.sv
// Youngest-first address match over the queued entries for one read port.
// Entry 0 is the oldest; a later valid match overrides an earlier one.
module wb_bypass_match
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [REG_ADDR_W-1:0]   raddr,
    input  wb_entry_t [DEPTH-1:0]   entries,
    input  logic [DEPTH-1:0]        valid,
    output logic                    hit,
    output logic [DATA_W-1:0]       data
);

    always_comb begin
        hit  = 1'b0;
        data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && raddr != '0 && entries[i].addr == raddr) begin
                hit  = 1'b1;
                data = entries[i].data;
            end
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Circular writeback FIFO draining into the register-file write port.
// Define WRITEBACK_QUEUE_BYPASS_EN to build the read-port bypass match.
module writeback_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  InValid,
    output logic                  InReady,
    input  logic [4:0]            InRegister,
    input  logic [31:0]           InData,
    input  logic                  DrainEnable,
    output logic [4:0]            WriteRegister,
    output logic [31:0]           WriteData,
    output logic                  RegWrite,
    input  logic [4:0]            ReadRegister1,
    input  logic [4:0]            ReadRegister2,
    output logic                  Hit1,
    output logic                  Hit2,
    output logic [31:0]           BypassData1,
    output logic [31:0]           BypassData2,
    output logic [$clog2(DEPTH):0] Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    wb_entry_t     mem [DEPTH];
    wb_entry_t     head_e;
    logic          push;
    logic          enq;

    assign InReady  = count < CW'(DEPTH);
    assign push     = InValid && InReady;
    // Writes to x0 complete the handshake but are dropped.
    assign enq      = push && InRegister != '0;
    assign RegWrite = count != '0 && DrainEnable;
    assign Count    = count;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + 1'b1;
            end
            if (RegWrite) begin
                head <= head + 1'b1;
            end
            unique case (1'b1)
                enq && !RegWrite: count <= count + 1'b1;
                !enq && RegWrite: count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (enq) begin
            mem[tail] <= '{addr: InRegister, data: InData};
        end
    end

    assign head_e        = mem[head];
    assign WriteRegister = count != '0 ? head_e.addr : '0;
    assign WriteData     = count != '0 ? head_e.data : '0;

`ifdef WRITEBACK_QUEUE_BYPASS_EN
    wb_entry_t [DEPTH-1:0] aged;
    logic [DEPTH-1:0]      aged_v;

    // Re-order storage oldest-to-youngest so the matcher can prioritise.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            aged[i]   = mem[head + PW'(i)];
            aged_v[i] = CW'(i) < count;
        end
    end

    wb_bypass_match #(.DEPTH(DEPTH)) u_match1 (
        .raddr   (ReadRegister1),
        .entries (aged),
        .valid   (aged_v),
        .hit     (Hit1),
        .data    (BypassData1)
    );

    wb_bypass_match #(.DEPTH(DEPTH)) u_match2 (
        .raddr   (ReadRegister2),
        .entries (aged),
        .valid   (aged_v),
        .hit     (Hit2),
        .data    (BypassData2)
    );
`else
    logic unused_rd;

    assign unused_rd   = ^{ReadRegister1, ReadRegister2};
    assign Hit1        = 1'b0;
    assign Hit2        = 1'b0;
    assign BypassData1 = '0;
    assign BypassData2 = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue with a drain-order scoreboard.
// Bypass expectations follow WRITEBACK_QUEUE_BYPASS_EN.
module tb_writeback_queue;
    import wb_pkg::*;

    localparam int DEPTH = 4;
`ifdef WRITEBACK_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_reg;
    logic [31:0] in_data;
    logic        drain;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic        reg_write;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic        hit1;
    logic        hit2;
    logic [31:0] bd1;
    logic [31:0] bd2;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    int cnt = 0;
    wb_entry_t sb[$];

    always #5 clk = ~clk;

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .Clk           (clk),
        .Rst_n         (rst_n),
        .InValid       (in_valid),
        .InReady       (in_ready),
        .InRegister    (in_reg),
        .InData        (in_data),
        .DrainEnable   (drain),
        .WriteRegister (wr_reg),
        .WriteData     (wr_data),
        .RegWrite      (reg_write),
        .ReadRegister1 (rr1),
        .ReadRegister2 (rr2),
        .Hit1          (hit1),
        .Hit2          (hit2),
        .BypassData1   (bd1),
        .BypassData2   (bd2),
        .Count         (count)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check outputs against the model, then advance one clock edge.
    task automatic tick();
        wb_entry_t front;
        logic      exp_rw;
        logic      acc;
        #1;
        chk("count", 32'(count), 32'(cnt));
        chk("in_ready", 32'(in_ready), 32'(cnt < DEPTH));
        exp_rw = cnt != 0 && drain;
        chk("reg_write", 32'(reg_write), 32'(exp_rw));
        if (exp_rw) begin
            front = sb.pop_front();
            chk("wr_reg", 32'(wr_reg), 32'(front.addr));
            chk("wr_data", wr_data, front.data);
        end else if (cnt == 0) begin
            chk("wr_reg_idle", 32'(wr_reg), 32'd0);
            chk("wr_data_idle", wr_data, 32'd0);
        end
        acc = in_valid && cnt < DEPTH;
        if (acc && in_reg != 5'd0) begin
            sb.push_back('{addr: in_reg, data: in_data});
        end
        cnt = cnt + int'(acc && in_reg != 5'd0) - int'(exp_rw);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic offer(logic [4:0] r, logic [31:0] d);
        in_valid = 1'b1;
        in_reg   = r;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_reg   = '0;
        in_data  = '0;
        drain    = 1'b1;
        rr1      = '0;
        rr2      = '0;
        @(negedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_hit1", 32'(hit1), 32'd0);
        chk("rst_hit2", 32'(hit2), 32'd0);
        chk("rst_wr_reg", 32'(wr_reg), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single entry into an empty queue drains on the next cycle.
        offer(5'd7, 32'd15);
        #1;
        chk("lat_reg_write", 32'(reg_write), 32'd1);
        chk("lat_wr_reg", 32'(wr_reg), 32'd7);
        chk("lat_wr_data", wr_data, 32'd15);
        tick();
        tick();

        // Fill, refuse a fifth offer, then drain in order.
        drain = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            offer(5'(i), 32'hA0 + 32'(i));
        end
        offer(5'd9, 32'h99);
        drain = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            tick();
        end

        // Duplicate addresses: youngest value wins the bypass.
        drain = 1'b0;
        offer(5'd2, 32'd42);
        offer(5'd2, 32'd5);
        rr1 = 5'd2;
        rr2 = 5'd3;
        #1;
        chk("byp_hit1", 32'(hit1), 32'(BYP));
        chk("byp_data1", bd1, BYP ? 32'd5 : 32'd0);
        chk("byp_hit2", 32'(hit2), 32'd0);
        chk("byp_data2", bd2, 32'd0);
        in_valid = 1'b1;
        in_reg   = 5'd2;
        in_data  = 32'd99;
        #1;
        chk("byp_offer_data1", bd1, BYP ? 32'd5 : 32'd0);
        in_valid = 1'b0;
        rr1   = 5'd2;
        drain = 1'b1;
        tick();
        #1;
        chk("byp_head_hit1", 32'(hit1), 32'(BYP));
        chk("byp_head_data1", bd1, BYP ? 32'd5 : 32'd0);
        tick();
        tick();
        chk("byp_empty_hit1", 32'(hit1), 32'd0);

        // Writes to x0 handshake but are never queued.
        offer(5'd0, 32'd5);
        tick();
        rr1 = 5'd0;
        #1;
        chk("x0_hit1", 32'(hit1), 32'd0);
        tick();

        // Full queue with a pop: push refused, then lands next edge.
        drain = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            offer(5'(10 + i), 32'h100 + 32'(i));
        end
        drain    = 1'b1;
        in_valid = 1'b1;
        in_reg   = 5'd14;
        in_data  = 32'h140;
        tick();
        drain = 1'b0;
        tick();
        in_valid = 1'b0;
        #1;
        chk("full_refill_count", 32'(count), 32'd4);
        drain = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            tick();
        end

        // Asynchronous reset mid-cycle discards queued entries.
        drain = 1'b0;
        offer(5'd20, 32'h200);
        offer(5'd21, 32'h201);
        offer(5'd22, 32'h202);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        drain = 1'b1;
        #1;
        chk("arst_reg_write", 32'(reg_write), 32'd0);
        sb.delete();
        cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
